// File: rtl/bs_bit_packer.sv
// ----------------------------------------------------------------------------
// bs_bit_packer
//   LSB-first bit packer for the zlib bitstream path. It collects
//   variable-length codes of 1..DATA_WD bits and emits DATA_WD-bit words in
//   DEFLATE bit order. The first transmitted bit of each code is at bit 0.
//   On flush the stream is zero-padded to a byte boundary. The remaining
//   bits are then drained. The final word is tagged with lst_o and carries
//   its valid byte count on byt_o.
//
// Ports
//   clk      in   1        clock, all logic on posedge
//   rstn     in   1        synchronous active-low reset
//   val_i    in   1        input code valid
//   rdy_o    out  1        packer can accept a code/flush this cycle
//   dat_i    in   DATA_WD  code bits, first-transmitted bit at dat_i[0]
//   len_i    in   LEN_WD   number of valid bits in dat_i (0 = no-op)
//   flush_i  in   1        end of stream request (qualified by rdy_o)
//   val_o    out  1        output word valid
//   rdy_i    in   1        downstream accepts word
//   dat_o    out  DATA_WD  packed word, byte 0 = dat_o[7:0]
//   byt_o    out  3        valid bytes in dat_o (DATA_WD/8 for non-final words)
//   lst_o    out  1        dat_o is the last word of the flushed stream
//   done_o   out  1        one-cycle pulse once a flush has fully drained
// ----------------------------------------------------------------------------
module bs_bit_packer #(
    parameter int DATA_WD = 32,
    parameter int LEN_WD  = 6
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               val_i,
    output logic               rdy_o,
    input  logic [DATA_WD-1:0] dat_i,
    input  logic [LEN_WD-1:0]  len_i,
    input  logic               flush_i,
    output logic               val_o,
    input  logic               rdy_i,
    output logic [DATA_WD-1:0] dat_o,
    output logic [2:0]         byt_o,
    output logic               lst_o,
    output logic               done_o
);

    localparam int ACC_WD = 2 * DATA_WD;
    localparam int CNT_WD = $clog2(ACC_WD) + 1;

    localparam logic [CNT_WD-1:0] WORD_BITS  = CNT_WD'(DATA_WD);
    localparam logic [CNT_WD-1:0] BYTE_MASK  = CNT_WD'(7);
    localparam logic [2:0]        WORD_BYTES = 3'(DATA_WD / 8);
    localparam logic [LEN_WD-1:0] MAX_LEN    = LEN_WD'(DATA_WD);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ACC_WD-1:0]   acc_q, acc_d;
    logic [CNT_WD-1:0]   cnt_q, cnt_d;

    logic [LEN_WD-1:0]   len_eff;
    logic [DATA_WD-1:0]  code_bits;
    logic [ACC_WD-1:0]   code_shifted;
    logic [CNT_WD-1:0]   cnt_acc;
    logic [CNT_WD-1:0]   cnt_rnd;

    // Over-long codes are clamped to a full word, so the accumulator can
    // never receive more than DATA_WD bits in one beat.
    assign len_eff = (len_i > MAX_LEN) ? MAX_LEN : len_i;

    // Keep only the low len_eff bits of the code. Bits above the code
    // length must not leak into the accumulator, because bits at and above
    // cnt_q are assumed to be zero.
    generate
        for (genvar gi = 0; gi < DATA_WD; gi++) begin : g_mask
            assign code_bits[gi] = dat_i[gi] & (LEN_WD'(gi) < len_eff);
        end
    endgenerate

    // An accept only happens while cnt_q < DATA_WD, so the shifted code
    // always fits in the double-width accumulator.
    assign code_shifted = {{DATA_WD{1'b0}}, code_bits} << cnt_q;

    assign cnt_acc = val_i ? (cnt_q + CNT_WD'(len_eff)) : cnt_q;
    // Round up to a whole byte. The padding bits are already zero.
    assign cnt_rnd = (cnt_acc + BYTE_MASK) & ~BYTE_MASK;

    // ------------------------------------------------------------------------
    // Output decode, taken only from state_q/acc_q/cnt_q (no path from rdy_i)
    // ------------------------------------------------------------------------
    always_comb begin
        rdy_o  = 1'b0;
        val_o  = 1'b0;
        byt_o  = 3'd0;
        lst_o  = 1'b0;
        done_o = 1'b0;
        dat_o  = acc_q[DATA_WD-1:0];
        case (state_q)
            ST_RUN: begin
                rdy_o = (cnt_q < WORD_BITS);
                val_o = (cnt_q >= WORD_BITS);
                byt_o = val_o ? WORD_BYTES : 3'd0;
            end
            ST_FLUSH: begin
                val_o = (cnt_q != '0);
                lst_o = val_o && (cnt_q <= WORD_BITS);
                if (!val_o) begin
                    byt_o = 3'd0;
                end else if (cnt_q >= WORD_BITS) begin
                    byt_o = WORD_BYTES;
                end else begin
                    byt_o = 3'(cnt_q >> 3);
                end
            end
            ST_DONE: begin
                done_o = 1'b1;
            end
            default: begin
                rdy_o = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (val_o) begin
                    // A full word is pending; rdy_o is low, so nothing is accepted.
                    if (rdy_i) begin
                        acc_d = acc_q >> DATA_WD;
                        cnt_d = cnt_q - WORD_BITS;
                    end
                end else if (rdy_o) begin
                    if (val_i) begin
                        acc_d = acc_q | code_shifted;
                        cnt_d = cnt_acc;
                    end
                    if (flush_i) begin
                        // If the stream is empty after padding, nothing needs
                        // to drain, so go straight to the done pulse.
                        cnt_d   = cnt_rnd;
                        state_d = (cnt_rnd == '0) ? ST_DONE : ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (cnt_q == '0) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else if (rdy_i) begin
                    if (lst_o) begin
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        acc_d = acc_q >> DATA_WD;
                        cnt_d = cnt_q - WORD_BITS;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
                acc_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_RUN;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
